// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared states and sizes for the instruction-memory loader
package imem_loader_pkg;
  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES = 2;
  localparam int CNT_W = 16;
  typedef enum logic [2:0] {
    IDLE, HDR_HI, HDR_LO, DATA, WRITE, DONE, ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
    , CHK
`endif
  } state_t;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte stream handshake plus instruction-memory write port
interface imem_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  modport master (output in_data, in_valid, input in_ready, wr_en, wr_addr, wr_data);
  modport slave  (input in_data, in_valid, output in_ready, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: shifts bytes MSB-first into a 32-bit word and flags the 4th push
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        push,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_out,
  output logic        word_full
);
  logic [31:0] r_shift;
  logic [1:0]  r_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (clear) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (push) begin
      r_shift <= {r_shift[23:0], byte_in};
      r_cnt   <= r_cnt + 2'd1;
    end
  end
  assign word_out  = r_shift;
  assign word_full = push && (r_cnt == 2'(BYTES_PER_WORD - 1));
endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time byte-stream to instruction-memory writer; optional IMEM_LOADER_CHECKSUM_EN
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  imem_loader_if.slave bus,
  output logic busy,
  output logic cpu_hold,
  output logic done,
  output logic error
);
  state_t           r_state, w_next;
  logic [7:0]       r_hi;
  logic [CNT_W-1:0] r_left;
  logic [31:0]      r_addr, r_last, w_word;
  logic [CNT_W-1:0] w_n;
  logic             w_accept, w_start, w_full, w_rx_state;
  assign w_n        = {r_hi, bus.in_data};
  assign w_start    = start && (r_state == IDLE || r_state == DONE || r_state == ERR);
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] r_xor;
  assign w_rx_state = r_state inside {HDR_HI, HDR_LO, DATA, CHK};
  assign busy       = r_state inside {HDR_HI, HDR_LO, DATA, WRITE, CHK};
`else
  assign w_rx_state = r_state inside {HDR_HI, HDR_LO, DATA};
  assign busy       = r_state inside {HDR_HI, HDR_LO, DATA, WRITE};
`endif
  // abort drops ready so a byte offered alongside it is never consumed
  assign bus.in_ready = w_rx_state && !abort;
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign cpu_hold     = busy;
  assign done         = r_state == DONE;
  assign error        = r_state == ERR;
  assign bus.wr_en    = r_state == WRITE;
  assign bus.wr_addr  = r_addr;
  assign bus.wr_data  = bus.wr_en ? w_word : r_last;
  byte_packer u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (w_start),
    .push     (w_accept && r_state == DATA),
    .byte_in  (bus.in_data),
    .word_out (w_word),
    .word_full(w_full)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    if (w_start) w_next = HDR_HI;
    else if (busy && abort) w_next = ERR;
    else case (r_state)
      HDR_HI: w_next = w_accept ? HDR_LO : HDR_HI;
      HDR_LO: w_next = !w_accept ? HDR_LO : (w_n == '0 || 32'(w_n) > MAX_WORDS) ? ERR : DATA;
      DATA:   w_next = w_full ? WRITE : DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
      WRITE:  w_next = (r_left == 16'd1) ? CHK : DATA;
      CHK:    w_next = !w_accept ? CHK : (bus.in_data == r_xor) ? DONE : ERR;
`else
      WRITE:  w_next = (r_left == 16'd1) ? DONE : DATA;
`endif
      default: w_next = r_state;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi   <= '0;
      r_left <= '0;
      r_addr <= BASE_ADDR;
      r_last <= '0;
    end else begin
      if (w_start) r_addr <= BASE_ADDR;
      if (r_state == HDR_HI && w_accept) r_hi <= bus.in_data;
      if (r_state == HDR_LO && w_accept) r_left <= w_n;
      if (r_state == WRITE) begin
        r_last <= w_word;
        r_addr <= r_addr + 32'(BYTES_PER_WORD);
        r_left <= r_left - 16'd1;
      end
    end
  end
`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_xor <= '0;
    else if (w_start)                    r_xor <= '0;
    else if (w_accept && r_state == DATA) r_xor <= r_xor ^ bus.in_data;
  end
`endif
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst_n, start, abort;
  logic busy, cpu_hold, done, error;
  int checks = 0;
  int errors = 0;
  int wcount = 0;
  int rdy_viol = 0;
  logic [31:0] waddr [8];
  logic [31:0] wdata [8];
  logic [7:0] tb_xor;

  imem_loader_if bus ();

  imem_loader dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .bus     (bus),
    .busy    (busy),
    .cpu_hold(cpu_hold),
    .done    (done),
    .error   (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.wr_en) begin
      if (wcount < 8) begin
        waddr[wcount] = bus.wr_addr;
        wdata[wcount] = bus.wr_data;
      end
      wcount = wcount + 1;
      if (bus.in_ready) rdy_viol = rdy_viol + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wcount = 0;
    rdy_viol = 0;
    tb_xor = 8'h00;
  endtask

  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    bus.in_data = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("ready_timeout", 32'(t < 40), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) begin
      send(w[31-8*i -: 8]);
      tb_xor = tb_xor ^ w[31-8*i -: 8];
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic end_stream();
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(tb_xor);
`endif
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    bus.in_data = 8'h00; bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_hold", cpu_hold, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_ready", bus.in_ready, 0);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_wr_addr", bus.wr_addr, 32'h0);
    chk("rst_wr_data", bus.wr_data, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // two-word load
    pulse_start();
    chk("t1_busy", busy, 1);
    chk("t1_hold", cpu_hold, 1);
    send(8'h00); send(8'h02);
    send_word(32'h0212_8020, 0);
    send_word(32'h0212_9022, 0);
    end_stream();
    chk("t1_wcount", wcount, 2);
    chk("t1_addr0", waddr[0], 32'h0);
    chk("t1_data0", wdata[0], 32'h0212_8020);
    chk("t1_addr1", waddr[1], 32'h4);
    chk("t1_data1", wdata[1], 32'h0212_9022);
    chk("t1_done", done, 1);
    chk("t1_busy_end", busy, 0);
    chk("t1_error", error, 0);
    chk("t1_hold_data", bus.wr_data, 32'h0212_9022);

    // zero word count
    pulse_start();
    send(8'h00); send(8'h00);
    chk("t2_error_now", error, 1);
    repeat (3) @(negedge clk);
    chk("t2_done", done, 0);
    chk("t2_wcount", wcount, 0);

    // 1025 words exceeds limit
    pulse_start();
    send(8'h04); send(8'h01);
    chk("t3_error_now", error, 1);
    repeat (3) @(negedge clk);
    chk("t3_busy", busy, 0);
    chk("t3_wcount", wcount, 0);

    // gapped single word
    pulse_start();
    send(8'h00); repeat (3) @(negedge clk);
    send(8'h01); repeat (3) @(negedge clk);
    send_word(32'hAABB_CCDD, 3);
    end_stream();
    chk("t4_wcount", wcount, 1);
    chk("t4_addr", waddr[0], 32'h0);
    chk("t4_data", wdata[0], 32'hAABB_CCDD);
    chk("t4_ready_in_write", rdy_viol, 0);
    chk("t4_done", done, 1);

    // abort mid second word, then reload
    pulse_start();
    send(8'h00); send(8'h02);
    send_word(32'h1122_3344, 0);
    send(8'h55); send(8'h66);
    @(negedge clk); abort = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h77;
    @(posedge clk); #1 abort = 1'b0; bus.in_valid = 1'b0;
    chk("t5_error", error, 1);
    chk("t5_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("t5_wcount", wcount, 1);
    chk("t5_data0", wdata[0], 32'h1122_3344);
    pulse_start();
    chk("t5_error_clear", error, 0);
    send(8'h00); send(8'h01);
    send_word(32'h0102_0304, 0);
    end_stream();
    chk("t5_re_wcount", wcount, 1);
    chk("t5_re_addr", waddr[0], 32'h0);
    chk("t5_re_data", wdata[0], 32'h0102_0304);
    chk("t5_re_done", done, 1);

    // async reset mid-word
    pulse_start();
    send(8'h00); send(8'h01);
    send(8'h01); send(8'h02);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_hold", cpu_hold, 0);
    chk("t6_ready", bus.in_ready, 0);
    chk("t6_done", done, 0);
    chk("t6_wr_data", bus.wr_data, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = 8'h03;
    repeat (6) @(negedge clk);
    bus.in_valid = 1'b0;
    chk("t6_wcount", wcount, 0);
    chk("t6_idle_busy", busy, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    pulse_start();
    send(8'h00); send(8'h01);
    send_word(32'h0102_0304, 0);
    send(8'h04);
    repeat (2) @(negedge clk);
    chk("t7_done", done, 1);
    chk("t7_wcount", wcount, 1);
    pulse_start();
    send(8'h00); send(8'h01);
    send_word(32'h0102_0304, 0);
    send(8'h05);
    repeat (2) @(negedge clk);
    chk("t7_bad_error", error, 1);
    chk("t7_bad_done", done, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
